// File: rtl/cic_interp32.sv
// cic_interp32: three-stage CIC interpolation filter, R = 2**LOG2R.
// The comb section runs at the low rate (one update per o_ready strobe), a
// zero-stuffer inserts R-1 zeros between comb outputs, and the integrator
// section runs on every edge of i_clk_high. Arithmetic is W-bit two's
// complement with wrap-around; W is full precision for gain R^2.
// Optional build macro CIC_INTERP_ROUND_EN: output is rounded half up with
// positive saturation instead of truncated, through one extra output register.
module cic_interp32 #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 12,
    parameter int LOG2R = 5
) (
    input  logic                    i_clk_high,
    input  logic                    i_reset,
    input  logic signed [IN_W-1:0]  i_signal,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic signed [OUT_W-1:0] o_signal,
    output logic                    o_underrun
);

    localparam int W  = IN_W + 2 * LOG2R;
    localparam int SH = W - OUT_W;
    localparam logic [LOG2R-1:0] CNT_LAST = '1;

    // rate divider and handshake state
    logic [LOG2R-1:0]    cnt_q, cnt_d;
    logic                s_q, s_d;
    logic                underrun_q, underrun_d;
    logic                strobe;

    // comb section (low rate)
    logic signed [W-1:0] x_q, x_d;
    logic signed [W-1:0] xd_q, xd_d;
    logic signed [W-1:0] c1_q, c1_d;
    logic signed [W-1:0] c1d_q, c1d_d;
    logic signed [W-1:0] c2_q, c2_d;
    logic signed [W-1:0] c2d_q, c2d_d;
    logic signed [W-1:0] c3_q, c3_d;

    // zero-stuffed sample and integrator section (high rate)
    logic signed [W-1:0] u_q, u_d;
    logic signed [W-1:0] i1_q, i1_d;
    logic signed [W-1:0] i2_q, i2_d;
    logic signed [W-1:0] i3_q, i3_d;

`ifdef CIC_INTERP_ROUND_EN
    localparam logic signed [W-1:0] HALF = {{(W-1){1'b0}}, 1'b1} << (SH - 1);

    logic signed [OUT_W-1:0] out_q, out_d;

    // Round half up; a positive carry into the sign bit saturates to the max code.
    function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [W-1:0] v);
        logic signed [W-1:0] sum;
        sum = v + HALF;
        if (!v[W-1] && sum[W-1]) begin
            round_sat = {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            round_sat = sum[W-1 -: OUT_W];
        end
    endfunction
`else
    // Keep the top OUT_W bits (floor toward minus infinity).
    function automatic logic signed [OUT_W-1:0] trunc_out(input logic signed [W-1:0] v);
        trunc_out = v[W-1 -: OUT_W];
    endfunction
`endif

    assign strobe     = (cnt_q == CNT_LAST);
    assign o_ready    = strobe;
    assign o_underrun = underrun_q;

`ifdef CIC_INTERP_ROUND_EN
    assign o_signal = out_q;
`else
    assign o_signal = trunc_out(i3_q);
`endif

    // Next-state: divider, strobe-gated capture and comb, stuffer, integrators.
    always_comb begin
        cnt_d      = cnt_q + 1'b1;
        s_d        = strobe;
        underrun_d = underrun_q;
        x_d        = x_q;
        xd_d       = xd_q;
        c1_d       = c1_q;
        c1d_d      = c1d_q;
        c2_d       = c2_q;
        c2d_d      = c2d_q;
        c3_d       = c3_q;

        if (strobe) begin
            if (i_valid) begin
                x_d = {{(W-IN_W){i_signal[IN_W-1]}}, i_signal};
            end else begin
                x_d        = '0;
                underrun_d = 1'b1;
            end
            xd_d  = x_q;
            c1_d  = x_q - xd_q;
            c1d_d = c1_q;
            c2_d  = c1_q - c1d_q;
            c2d_d = c2_q;
            c3_d  = c2_q - c2d_q;
        end

        u_d  = s_q ? c3_q : '0;
        i1_d = i1_q + u_q;
        i2_d = i2_q + i1_q;
        i3_d = i3_q + i2_q;
`ifdef CIC_INTERP_ROUND_EN
        out_d = round_sat(i3_q);
`endif
    end

    // State registers; reset discards all filter state immediately.
    always_ff @(posedge i_clk_high or posedge i_reset) begin
        if (i_reset) begin
            cnt_q      <= '0;
            s_q        <= 1'b0;
            underrun_q <= 1'b0;
            x_q        <= '0;
            xd_q       <= '0;
            c1_q       <= '0;
            c1d_q      <= '0;
            c2_q       <= '0;
            c2d_q      <= '0;
            c3_q       <= '0;
            u_q        <= '0;
            i1_q       <= '0;
            i2_q       <= '0;
            i3_q       <= '0;
`ifdef CIC_INTERP_ROUND_EN
            out_q      <= '0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            s_q        <= s_d;
            underrun_q <= underrun_d;
            x_q        <= x_d;
            xd_q       <= xd_d;
            c1_q       <= c1_d;
            c1d_q      <= c1d_d;
            c2_q       <= c2_d;
            c2d_q      <= c2d_d;
            c3_q       <= c3_d;
            u_q        <= u_d;
            i1_q       <= i1_d;
            i2_q       <= i2_d;
            i3_q       <= i3_d;
`ifdef CIC_INTERP_ROUND_EN
            out_q      <= out_d;
`endif
        end
    end

endmodule

// File: tb/tb_cic_interp32.sv
// tb_cic_interp32: randomized scoreboard bench for cic_interp32.
// Reference: the interpolator output equals the zero-stuffed low-rate sample
// stream convolved with the CIC impulse response (a length-R box filter
// convolved with itself three times), offset by the pipeline latency.
module tb_cic_interp32;

    localparam int IN_W  = 10;
    localparam int OUT_W = 12;
    localparam int LOG2R = 5;
    localparam int R     = 1 << LOG2R;
    localparam int W     = IN_W + 2 * LOG2R;
    localparam int SH    = W - OUT_W;
    localparam int HLEN  = 3 * R - 2;
    localparam int FIRST = 3 * R + 4;
`ifdef CIC_INTERP_ROUND_EN
    localparam int OLAT = 1;
`else
    localparam int OLAT = 0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic signed [IN_W-1:0]  sig;
    logic                    vld;
    logic                    rdy;
    logic signed [OUT_W-1:0] osig;
    logic                    und;

    cic_interp32 #(.IN_W(IN_W), .OUT_W(OUT_W), .LOG2R(LOG2R)) dut (
        .i_clk_high (clk),
        .i_reset    (rst),
        .i_signal   (sig),
        .i_valid    (vld),
        .o_ready    (rdy),
        .o_signal   (osig),
        .o_underrun (und)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     e;
        logic   rdy;
        longint o;
        logic   und;
    } exp_t;

    exp_t   sb[$];
    int     vectors     = 0;
    int     miscompares = 0;
    longint h[0:HLEN-1];
    int     samp[0:1023];
    int     e;
    logic   und_m;

    task automatic check(input string nm, input longint act, input longint expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Full-precision integrator output after edge ee (edges counted from reset release).
    function automatic longint i3_model(input int ee);
        longint acc = 0;
        for (int k = 1; k * R <= ee && k < 1024; k++) begin
            int m = ee - k * R - FIRST;
            if (m >= 0 && m < HLEN) acc += longint'(samp[k]) * h[m];
        end
        return acc;
    endfunction

    function automatic longint out_model(input int ee);
        longint acc = i3_model(ee - OLAT);
`ifdef CIC_INTERP_ROUND_EN
        longint r = acc + (longint'(1) <<< (SH - 1));
        if (r > (longint'(1) <<< (W - 1)) - 1) return (longint'(1) <<< (OUT_W - 1)) - 1;
        return r >>> SH;
`else
        return acc >>> SH;
`endif
    endfunction

    // Monitor: the DUT presents a sample every cycle; compare on the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            check("o_ready",    longint'(rdy),  longint'(x.rdy));
            check("o_signal",   longint'(osig), x.o);
            check("o_underrun", longint'(und),  longint'(x.und));
        end
    end

    // Assert reset asynchronously in the low phase, check immediate clear, hold 3 edges.
    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        check("async_rst_ready",    longint'(rdy),  0);
        check("async_rst_signal",   longint'(osig), 0);
        check("async_rst_underrun", longint'(und),  0);
        e     = 0;
        und_m = 1'b0;
        for (int k = 0; k < 1024; k++) samp[k] = 0;
        repeat (3) begin
            @(posedge clk);
            sb.push_back('{0, 1'b0, 0, 1'b0});
            @(negedge clk);
        end
        #1 rst = 1'b0;
    endtask

    // kind 0: constant p; 1: impulse p on first strobe then 0;
    // 2: random samples with occasional missing valid; 3: constant p, valid dropped on 3rd strobe.
    task automatic run(input int ncyc, input int kind, input int p);
        int nstrobe = 0;
        for (int c = 0; c < ncyc; c++) begin
            vld = 1'($urandom_range(0, 1));
            sig = IN_W'($urandom_range(0, (1 << IN_W) - 1));
            if (((e + 1) % R) == 0) begin
                nstrobe++;
                vld = 1'b1;
                case (kind)
                    0: sig = IN_W'(p);
                    1: sig = (nstrobe == 1) ? IN_W'(p) : '0;
                    2: vld = ($urandom_range(0, 9) != 0);
                    default: begin
                        sig = IN_W'(p);
                        if (nstrobe == 3) vld = 1'b0;
                    end
                endcase
            end
            @(posedge clk);
            e++;
            if ((e % R) == 0 && (e / R) < 1024) begin
                samp[e / R] = vld ? int'(sig) : 0;
                if (!vld) und_m = 1'b1;
            end
            sb.push_back('{e, ((e % R) == R - 1), out_model(e), und_m});
            @(negedge clk);
        end
    endtask

    initial begin
        rst   = 1'b1;
        vld   = 1'b0;
        sig   = '0;
        e     = 0;
        und_m = 1'b0;
        for (int m = 0; m < HLEN; m++) h[m] = 0;
        for (int a = 0; a < R; a++)
            for (int b = 0; b < R; b++)
                for (int c = 0; c < R; c++)
                    h[a + b + c] += 1;
        @(negedge clk);
        do_reset();
        run(100, 0, 0);
        run(7 * R + 10, 0, 100);
        run(8 * R, 0, -512);
        run(5 * R, 1, 511);
        run(4 * R, 0, 0);
        do_reset();
        run(10 * R, 3, 100);
        do_reset();
        run(20 * R, 2, 0);
        do_reset();
        run(2 * R + 5, 0, 100);
        do_reset();
        run(8 * R, 0, 100);
        #1;
        check("scoreboard_drained", longint'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cic_interp32.md
Name: cic_interp32

Overview:
- Three-stage CIC interpolation filter. Default interpolation factor R = 32; input and output are signed two's-complement.
- Accepts one low-rate sample every R cycles of i_clk_high and produces one high-rate output sample every cycle.
- Companion to the cic32 decimator. It sits on the transmit/upconversion side and uses the same single fast clock plus an internal rate divider.
- Structure: comb section (low rate) -> zero-stuffer -> integrator section (high rate).

Parameters:
- IN_W, 10, input sample width (signed).
- OUT_W, 12, output sample width (signed); must be <= W.
- LOG2R, 5, log2 of the interpolation factor; R = 2**LOG2R.
- W (derived localparam), IN_W + 2*LOG2R = 20. Internal datapath width for all comb and integrator registers. Equals full-precision growth, since gain is R^2.

Ports:
- i_clk_high  in   1      fast clock; all logic on its rising edge
- i_reset     in   1      asynchronous, active-high reset
- i_signal    in   IN_W   low-rate input sample, signed
- i_valid     in   1      upstream has a sample on i_signal
- o_ready     out  1      sample-request strobe; high exactly one cycle in R
- o_signal    out  OUT_W  high-rate output sample, signed; new value every cycle
- o_underrun  out  1      sticky flag; set if o_ready was high while i_valid was low

Behaviour:
- Reset (async):
  - All counters, comb, delay and integrator registers clear to 0.
  - o_ready = 0, o_signal = 0, o_underrun = 0.
  - Reset asserted mid-operation discards all filter state immediately.
- Rate divider:
  - LOG2R-bit counter increments every cycle and wraps R-1 -> 0.
  - o_ready = (counter == R-1), combinational from the counter register.
  - First o_ready occurs R-1 cycles after reset release.
- Handshake, at a strobe edge S (edge where o_ready = 1):
  - If i_valid = 1: x <= i_signal, sign-extended to W.
  - If i_valid = 0: x <= 0 and o_underrun <= 1 (held until reset).
  - i_valid/i_signal are ignored while o_ready = 0. No back-pressure toward upstream.
- Comb section: updates only at strobe edges; holds otherwise. Registered pipeline, all W bits, modular arithmetic:
  - xd <= x;   c1 <= x - xd
  - c1d <= c1; c2 <= c1 - c1d
  - c2d <= c2; c3 <= c2 - c2d
- Zero-stuffer:
  - s_q is the strobe registered one cycle.
  - u <= s_q ? c3 : 0 on every edge, so exactly one nonzero slot per R cycles.
- Integrator section: updates every edge, W bits, wrap-around (two's-complement) arithmetic, no saturation:
  - i1 <= i1 + u
  - i2 <= i2 + i1
  - i3 <= i3 + i2
- Output: o_signal = i3[W-1 : W-OUT_W] (truncation), a combinational slice of the register.
- Latency:
  - A sample captured at strobe edge S0 first affects c3 at S0+3R and i3 at edge S0+3R+4.
  - The impulse response spans 3R-2 high-rate cycles.
- DC gain is R^2. A constant input A gives i3 = A*R^2 in steady state; default output = A*4.
- Overflow: cannot occur for in-range input because W is full-precision. Wrap is by design if parameters are altered.

Optional Feature:
- Macro: CIC_INTERP_ROUND_EN
- Defined:
  - Output = i3 + 2**(W-OUT_W-1), then sliced (round half up).
  - If the addition overflows positive, o_signal saturates to the OUT_W maximum (+2047 default).
  - Adds one register stage, so o_signal latency increases by 1 cycle.
- Undefined: plain truncation as above; no extra stage.

Test Plan:
- Reset release, i_valid held 1, i_signal = 0 -> o_ready high on cycles 31, 63, 95, ... after release; o_signal = 0 throughout; o_underrun = 0.
- Step input i_signal = 100 from first strobe S0 -> o_signal monotonic non-decreasing; equals 400 from edge S0+6R+4 onward.
- i_signal = -512 constant -> steady o_signal = -2048; no wrap; with CIC_INTERP_ROUND_EN also -2048.
- Single impulse 511 at S0, then 0 -> i3 nonzero first at S0+3R+4; returns to 0 after 3R-2 cycles; o_signal returns to 0 and stays 0.
- i_valid = 0 during one strobe with steady input 100 -> o_underrun sets on that edge and stays 1; transient dip in output; returns to 400 within 6R cycles.
- Assert i_reset mid-step for 3 cycles -> all outputs 0 asynchronously; counter restarts; next o_ready 31 cycles after release.
